// File: rtl/id_stage_if.sv
// id_stage bus: fetch handshake, execute bundle handshake, writeback port
// and the sticky illegal flag. slave = decode stage, master = its neighbours.
interface id_stage_if;
  logic        in_valid;
  logic [15:0] in_instr;
  logic        in_ready;
  logic        ex_valid;
  logic        ex_ready;
  logic [3:0]  ex_opcode;
  logic [7:0]  ex_a;
  logic [7:0]  ex_b;
  logic [2:0]  ex_rd;
  logic        ex_we;
  logic        wb_en;
  logic [2:0]  wb_addr;
  logic [7:0]  wb_data;
  logic        illegal;

  modport slave (
    input  in_valid, in_instr, ex_ready,
    input  wb_en, wb_addr, wb_data,
    output in_ready, ex_valid, ex_opcode,
    output ex_a, ex_b, ex_rd, ex_we, illegal
  );

  modport master (
    output in_valid, in_instr, ex_ready,
    output wb_en, wb_addr, wb_data,
    input  in_ready, ex_valid, ex_opcode,
    input  ex_a, ex_b, ex_rd, ex_we, illegal
  );
endinterface

// File: rtl/id_stage.sv
// id_stage: decode, 8x8 register file, busy scoreboard, execute bundle.
// Ports: clk, rst_n (async low), bus (id_stage_if.slave: in_*, ex_*, wb_*,
// illegal). Define ID_BYPASS_EN to forward wb_data to same-cycle sources.
module id_stage #(
  parameter logic [7:0] REG_RESET = 8'h00
) (
  input  logic       clk,
  input  logic       rst_n,
  id_stage_if.slave  bus
);
  typedef struct packed {
    logic [3:0] op;
    logic [7:0] a;
    logic [7:0] b;
    logic [2:0] rd;
    logic       we;
  } id_ex_t;

  logic [7:0] r_rf [8];
  logic [7:0] r_busy;
  id_ex_t     r_ex;
  logic       r_ex_valid;
  logic       r_illegal;

  logic [3:0] w_op;
  logic [2:0] w_rd;
  logic [2:0] w_rs1;
  logic [2:0] w_rs2;
  logic [7:0] w_imm;
  logic       w_alu;
  logic       w_ldi;
  logic       w_legal;
  logic       w_use2;
  logic [7:0] w_clr;
  logic [7:0] w_sbusy;
  logic [7:0] w_dbusy;
  logic [7:0] w_set;
  logic [7:0] w_v1;
  logic [7:0] w_v2;
  logic       w_haz;
  logic       w_ready;
  logic       w_acc;
  id_ex_t     w_nxt;

  assign w_op  = bus.in_instr[15:12];
  assign w_rd  = bus.in_instr[11:9];
  assign w_rs1 = bus.in_instr[8:6];
  assign w_rs2 = bus.in_instr[5:3];
  assign w_imm = bus.in_instr[7:0];

  always_comb begin
    w_alu = 1'b0;
    w_ldi = 1'b0;
    unique case (1'b1)
      (w_op <= 4'd5): w_alu = 1'b1;
      (w_op == 4'd8): w_ldi = 1'b1;
      default: ;
    endcase
  end

  assign w_legal = w_alu | w_ldi;
  // NOT has no second source
  assign w_use2  = w_alu & (w_op != 4'd2);

  always_comb begin
    w_clr = '0;
    if (bus.wb_en && bus.wb_addr != 3'd0)
      w_clr[bus.wb_addr] = 1'b1;
  end

  // rd (WAW) always waits for the clear to land; sources only
  // skip the wait when the writeback value can be forwarded.
  assign w_dbusy = r_busy & ~w_clr;
`ifdef ID_BYPASS_EN
  assign w_sbusy = r_busy & ~w_clr;
`else
  assign w_sbusy = r_busy;
`endif

  assign w_haz = w_legal & (
    (w_alu & w_sbusy[w_rs1]) |
    (w_use2 & w_sbusy[w_rs2]) |
    w_dbusy[w_rd]);

  assign w_ready = !w_haz && (!r_ex_valid || bus.ex_ready);
  assign w_acc   = bus.in_valid && w_ready;

  always_comb begin
    w_v1 = (w_rs1 == 3'd0) ? 8'h00 : r_rf[w_rs1];
    w_v2 = (w_rs2 == 3'd0) ? 8'h00 : r_rf[w_rs2];
`ifdef ID_BYPASS_EN
    if (w_clr[w_rs1]) w_v1 = bus.wb_data;
    if (w_clr[w_rs2]) w_v2 = bus.wb_data;
`endif
  end

  always_comb begin
    w_nxt.op = w_ldi ? 4'd0 : w_op;
    w_nxt.a  = w_ldi ? 8'h00 : w_v1;
    w_nxt.b  = w_ldi ? w_imm : (w_use2 ? w_v2 : 8'h00);
    w_nxt.rd = w_rd;
    w_nxt.we = (w_rd != 3'd0);
  end

  always_comb begin
    w_set = '0;
    if (w_acc && w_legal && w_nxt.we)
      w_set[w_rd] = 1'b1;
  end

  // set wins over a same-cycle clear of the same register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_busy <= '0;
      for (int i = 0; i < 8; i++)
        r_rf[i] <= REG_RESET;
    end else begin
      r_busy <= (r_busy & ~w_clr) | w_set;
      if (bus.wb_en && bus.wb_addr != 3'd0)
        r_rf[bus.wb_addr] <= bus.wb_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ex       <= '0;
      r_ex_valid <= 1'b0;
      r_illegal  <= 1'b0;
    end else begin
      if (w_acc && w_legal) begin
        r_ex       <= w_nxt;
        r_ex_valid <= 1'b1;
      end else if (bus.ex_ready) begin
        r_ex_valid <= 1'b0;
      end
      if (w_acc && !w_legal)
        r_illegal <= 1'b1;
    end
  end

  assign bus.in_ready  = w_ready;
  assign bus.ex_valid  = r_ex_valid;
  assign bus.ex_opcode = r_ex.op;
  assign bus.ex_a      = r_ex.a;
  assign bus.ex_b      = r_ex.b;
  assign bus.ex_rd     = r_ex.rd;
  assign bus.ex_we     = r_ex.we;
  assign bus.illegal   = r_illegal;
endmodule
